// File: rtl/dma_rd_arb_pkg.sv
// dma_rd_arb_pkg: shared definitions for the DMA read-side arbiter.
//   state_t            - arbiter FSM encoding (IDLE/ISSUE/BUSY/DONE)
//   DEF_BITS_TRANS     - default transfer-count width (32-bit words)
//   DEF_AXI_WIDTH_AD   - default DMA start address width
//   DEF_AXI_WIDTH_DA   - default DMA data width
package dma_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_BITS_TRANS   = 18;
  localparam int DEF_AXI_WIDTH_AD = 32;
  localparam int DEF_AXI_WIDTH_DA = 32;

endpackage

// File: rtl/dma_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req starting at index ptr, moving upward and wrapping; the first
// set bit wins.
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    index with top priority (must be < NUM_REQ)
//   gnt  out NUM_REQ  one-hot winner (all zero when no request)
//   idx  out IDX_W    binary index of the winner
//   any  out 1        at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_rot;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;
  logic               found;

  // Rotate so that bit 0 of req_rot is req[ptr]; a fixed-priority search from
  // bit 0 then implements the round-robin order.
  assign req_rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    gnt_rot = '0;
    off     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found      = 1'b1;
        gnt_rot[i] = 1'b1;
        off        = (IDX_W+1)'(i);
      end
    end
  end

  // Rotate the one-hot result back into requester numbering.
  assign gnt = NUM_REQ'(({gnt_rot, gnt_rot} << ptr) >> NUM_REQ);
  assign sum = {1'b0, ptr} + off;
  assign idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                            : IDX_W'(sum);
  assign any = found;

endmodule

// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares one axi_dma_rd read engine among NUM_REQ requesters.
// A round-robin winner is picked in IDLE, its descriptor is latched onto the
// DMA functional ports, a one-cycle start_dma is issued, and the DMA data
// valid / done are steered back to the granted requester only.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_i                per-requester request level
//   req_num_trans_i      flattened transfer counts, slice k = requester k
//   req_start_addr_i     flattened start addresses, slice k = requester k
//   gnt_o                one-hot grant held for the whole transaction
//   done_o               one-cycle completion pulse to the granted requester
//   data_o, data_cnt_o   broadcast pass-through of DMA data / beat count
//   data_vld_o           DMA data valid qualified by grant, only in BUSY
//   busy_o               high whenever the arbiter is not IDLE
//   dma_din, dma_din_vld, dma_data_cnt, dma_done   from axi_dma_rd
//   start_dma, dma_num_trans, dma_start_addr      to axi_dma_rd
// Optional feature macro DMA_RD_ARB_WDOG_EN: adds parameter TIMEOUT_CYC and
// output err_o; a BUSY phase lasting TIMEOUT_CYC cycles without dma_done is
// abandoned with a one-cycle err_o pulse and no done_o.
module dma_rd_arbiter
  import dma_rd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int BITS_TRANS   = DEF_BITS_TRANS,
  parameter int AXI_WIDTH_AD = DEF_AXI_WIDTH_AD,
  parameter int AXI_WIDTH_DA = DEF_AXI_WIDTH_DA
`ifdef DMA_RD_ARB_WDOG_EN
  ,
  parameter int TIMEOUT_CYC  = 65535
`endif
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*BITS_TRANS-1:0]   req_num_trans_i,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0] req_start_addr_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic [AXI_WIDTH_DA-1:0]         data_o,
  output logic [NUM_REQ-1:0]              data_vld_o,
  output logic [BITS_TRANS-1:0]           data_cnt_o,
  output logic                            busy_o,
  input  logic [AXI_WIDTH_DA-1:0]         dma_din,
  input  logic                            dma_din_vld,
  input  logic [BITS_TRANS-1:0]           dma_data_cnt,
  input  logic                            dma_done,
  output logic                            start_dma,
  output logic [BITS_TRANS-1:0]           dma_num_trans,
  output logic [AXI_WIDTH_AD-1:0]         dma_start_addr
`ifdef DMA_RD_ARB_WDOG_EN
  ,
  output logic                            err_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                    state, state_nx;
  logic [NUM_REQ-1:0]        gnt_nx;
  logic [IDX_W-1:0]          win_idx, win_idx_nx;
  logic [IDX_W-1:0]          ptr, ptr_nx;
  logic [BITS_TRANS-1:0]     num_trans_nx;
  logic [AXI_WIDTH_AD-1:0]   start_addr_nx;

  logic [NUM_REQ-1:0]        pick_gnt;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  logic [BITS_TRANS-1:0]     sel_num_trans;
  logic [AXI_WIDTH_AD-1:0]   sel_start_addr;

  // Pointer holds the index with top priority, i.e. last winner + 1.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Descriptor mux driven by the one-hot pick.
  always_comb begin
    sel_num_trans  = '0;
    sel_start_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_num_trans  = req_num_trans_i[k*BITS_TRANS +: BITS_TRANS];
        sel_start_addr = req_start_addr_i[k*AXI_WIDTH_AD +: AXI_WIDTH_AD];
      end
    end
  end

`ifdef DMA_RD_ARB_WDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            err_nx;

  // Counts BUSY cycles; held at zero elsewhere so it restarts on BUSY entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (state != ST_BUSY) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYC-th BUSY cycle.
  assign wd_hit = (state == ST_BUSY) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err_o  = err_nx;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      gnt_o          <= '0;
      win_idx        <= '0;
      ptr            <= '0;
      dma_num_trans  <= '0;
      dma_start_addr <= '0;
    end else begin
      state          <= state_nx;
      gnt_o          <= gnt_nx;
      win_idx        <= win_idx_nx;
      ptr            <= ptr_nx;
      dma_num_trans  <= num_trans_nx;
      dma_start_addr <= start_addr_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt_o;
    win_idx_nx    = win_idx;
    ptr_nx        = ptr;
    num_trans_nx  = dma_num_trans;
    start_addr_nx = dma_start_addr;
`ifdef DMA_RD_ARB_WDOG_EN
    err_nx        = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nx        = pick_gnt;
          win_idx_nx    = pick_idx;
          num_trans_nx  = sel_num_trans;
          start_addr_nx = sel_start_addr;
          // Zero-length transfers never touch the DMA engine.
          state_nx      = (sel_num_trans == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (dma_done) begin
          state_nx = ST_DONE;
        end
`ifdef DMA_RD_ARB_WDOG_EN
        else if (wd_hit) begin
          err_nx   = 1'b1;
          gnt_nx   = '0;
          ptr_nx   = next_idx(win_idx);
          state_nx = ST_IDLE;
        end
`endif
      end
      ST_DONE: begin
        gnt_nx   = '0;
        ptr_nx   = next_idx(win_idx);
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  assign start_dma  = (state == ST_ISSUE);
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = gnt_o & {NUM_REQ{state == ST_DONE}};
  // DMA beats outside BUSY are dropped.
  assign data_vld_o = gnt_o & {NUM_REQ{dma_din_vld && (state == ST_BUSY)}};
  assign data_o     = dma_din;
  assign data_cnt_o = dma_data_cnt;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb_dma_rd_arbiter: randomized transaction-level bench for dma_rd_arbiter
// with three requesters and a behavioural round-robin / timing model.
module tb_dma_rd_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int BT = 18;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_i;
  logic [N*BT-1:0] req_num_trans_i;
  logic [N*AW-1:0] req_start_addr_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic [DW-1:0]   data_o;
  logic [N-1:0]    data_vld_o;
  logic [BT-1:0]   data_cnt_o;
  logic            busy_o;
  logic [DW-1:0]   dma_din;
  logic            dma_din_vld;
  logic [BT-1:0]   dma_data_cnt;
  logic            dma_done;
  logic            start_dma;
  logic [BT-1:0]   dma_num_trans;
  logic [AW-1:0]   dma_start_addr;

  dma_rd_arbiter #(
    .NUM_REQ      (N),
    .BITS_TRANS   (BT),
    .AXI_WIDTH_AD (AW),
    .AXI_WIDTH_DA (DW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req_i            (req_i),
    .req_num_trans_i  (req_num_trans_i),
    .req_start_addr_i (req_start_addr_i),
    .gnt_o            (gnt_o),
    .done_o           (done_o),
    .data_o           (data_o),
    .data_vld_o       (data_vld_o),
    .data_cnt_o       (data_cnt_o),
    .busy_o           (busy_o),
    .dma_din          (dma_din),
    .dma_din_vld      (dma_din_vld),
    .dma_data_cnt     (dma_data_cnt),
    .dma_done         (dma_done),
    .start_dma        (start_dma),
    .dma_num_trans    (dma_num_trans),
    .dma_start_addr   (dma_start_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side model: pending requests, their descriptors, last winner.
  logic [N-1:0]  pend;
  logic [BT-1:0] nt_arr [N];
  logic [AW-1:0] ad_arr [N];
  int            last;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First pending requester found searching upward from last+1, wrapping.
  function automatic int rr_winner(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (lst + i) % N;
      if (r[IW'(k)]) return k;
    end
    return 0;
  endfunction

  task automatic drive_req();
    req_i = pend;
    for (int k = 0; k < N; k++) begin
      req_num_trans_i[k*BT +: BT]  = nt_arr[IW'(k)];
      req_start_addr_i[k*AW +: AW] = ad_arr[IW'(k)];
    end
  endtask

  // One complete transaction, entered and left in an IDLE cycle.
  task automatic run_txn(input logic [N-1:0] add_in);
    logic [N-1:0]  add;
    logic [N-1:0]  oh;
    logic [BT-1:0] ent;
    logic [AW-1:0] ead;
    logic          v;
    int            w;
    int            b;
    add = add_in;
    if ((pend | add) == '0) add[IW'($urandom_range(0, N-1))] = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (add[k] && !pend[k]) begin
        ad_arr[IW'(k)] = $urandom;
        nt_arr[IW'(k)] = ($urandom_range(0, 3) == 0) ? '0 : BT'($urandom_range(1, 6));
      end
    end
    pend = pend | add;
    drive_req();
    dma_din_vld = 1'($urandom_range(0, 1));
    dma_din     = $urandom;
    #1;
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("idle_gnt", 64'(gnt_o), 64'(0));
    chk("idle_vld", 64'(data_vld_o), 64'(0));
    chk("idle_start", 64'(start_dma), 64'(0));

    w   = rr_winner(pend, last);
    oh  = N'(1) << w;
    ent = nt_arr[IW'(w)];
    ead = ad_arr[IW'(w)];

    tick();  // sample edge
    dma_din_vld = 1'($urandom_range(0, 1));
    dma_done    = (ent != '0) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("grant", 64'(gnt_o), 64'(oh));
    chk("busy", 64'(busy_o), 64'(1));
    chk("num_trans", 64'(dma_num_trans), 64'(ent));
    chk("start_addr", 64'(dma_start_addr), 64'(ead));
    chk("start_pulse", 64'(start_dma), 64'(ent != '0));
    chk("done_zero_len", 64'(done_o), (ent == '0) ? 64'(oh) : 64'(0));
    chk("early_vld", 64'(data_vld_o), 64'(0));

    if (ent != '0) begin
      tick();  // into BUSY; a dma_done in ISSUE must have been ignored
      dma_done    = 1'b0;
      dma_din_vld = 1'b0;
      b = 0;
      while (b < int'(ent)) begin
        v            = 1'($urandom_range(0, 1));
        dma_din_vld  = v;
        dma_din      = $urandom;
        dma_data_cnt = BT'(b);
        #1;
        chk("beat_vld", 64'(data_vld_o), v ? 64'(oh) : 64'(0));
        chk("beat_data", 64'(data_o), 64'(dma_din));
        chk("beat_cnt", 64'(data_cnt_o), 64'(b));
        chk("busy_start", 64'(start_dma), 64'(0));
        chk("busy_done", 64'(done_o), 64'(0));
        chk("busy_gnt", 64'(gnt_o), 64'(oh));
        if (v) b++;
        tick();
      end
      dma_din_vld = 1'b0;
      dma_done    = 1'b1;
      tick();
      dma_done = 1'b0;
      #1;
      chk("done_pulse", 64'(done_o), 64'(oh));
      chk("done_gnt", 64'(gnt_o), 64'(oh));
      chk("done_start", 64'(start_dma), 64'(0));
    end

    // Winner withdraws in the done_o cycle; losers keep requesting.
    pend[IW'(w)] = 1'b0;
    drive_req();
    last = w;
    tick();
  endtask

  initial begin
    rstn             = 1'b0;
    req_i            = '0;
    req_num_trans_i  = '0;
    req_start_addr_i = '0;
    dma_din          = '0;
    dma_din_vld      = 1'b1;
    dma_data_cnt     = '0;
    dma_done         = 1'b0;
    pend             = '0;
    last             = N - 1;
    for (int k = 0; k < N; k++) begin
      nt_arr[k] = '0;
      ad_arr[k] = '0;
    end

    repeat (2) tick();
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_start", 64'(start_dma), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_nt", 64'(dma_num_trans), 64'(0));
    chk("rst_addr", 64'(dma_start_addr), 64'(0));
    chk("rst_vld", 64'(data_vld_o), 64'(0));
    rstn        = 1'b1;
    dma_din_vld = 1'b0;
    tick();

    // Two requesters held high together must alternate 0,1,0,1.
    for (int t = 0; t < 4; t++) run_txn(3'b011);
    for (int t = 0; t < 40; t++) run_txn(N'($urandom));

    // Reset in the middle of a BUSY phase.
    pend = '0;
    drive_req();
    tick();
    nt_arr[0] = BT'(64);
    ad_arr[0] = 32'h1000;
    pend      = 3'b001;
    drive_req();
    tick();
    #1;
    chk("mid_gnt", 64'(gnt_o), 64'(3'b001));
    chk("mid_start", 64'(start_dma), 64'(1));
    chk("mid_nt", 64'(dma_num_trans), 64'(64));
    chk("mid_addr", 64'(dma_start_addr), 64'(32'h1000));
    tick();
    for (int i = 0; i < 10; i++) begin
      dma_din_vld = 1'b1;
      #1;
      chk("mid_beat", 64'(data_vld_o), 64'(3'b001));
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt_o), 64'(0));
    chk("arst_start", 64'(start_dma), 64'(0));
    chk("arst_done", 64'(done_o), 64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_vld", 64'(data_vld_o), 64'(0));
    dma_din_vld = 1'b0;
    pend        = '0;
    drive_req();
    tick();
    rstn = 1'b1;
    last = N - 1;
    tick();
    nt_arr[1] = BT'(3);
    ad_arr[1] = 32'h2000;
    nt_arr[2] = BT'(5);
    ad_arr[2] = 32'h3000;
    pend      = 3'b110;
    drive_req();
    tick();
    #1;
    chk("post_rst_gnt", 64'(gnt_o), 64'(N'(1) << rr_winner(3'b110, last)));
    chk("post_rst_addr", 64'(dma_start_addr), 64'(32'h2000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
